// File: rtl/mfic_det_packer.sv
// Peak detector and report packer behind the matched-filter integrator.
// Finds local maxima above threshold and queues 100-bit reports in a FWFT FIFO.
module mfic_det_packer #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_DET    = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sweep_start,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_vld,
    input  logic [WIDTH-1:0] threshold,
    input  logic [15:0]      azimuth,
    output logic [99:0]      word,
    output logic             wr_word,
    input  logic             word_rdy,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic             armed;
    logic [15:0]      az_q;
    logic [15:0]      sweep_cnt;
    logic [15:0]      range_idx;
    logic [11:0]      det_num;
    logic             ovf_pend;

    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    logic             w1_vld;
    logic             w2_vld;
    logic [15:0]      r1;

    logic             pend_vld;
    logic [15:0]      pend_az;
    logic [15:0]      pend_rng;
    logic [WIDTH-1:0] pend_amp;
    logic [15:0]      pend_sw;
    logic             pend_edge;

    logic [99:0]      mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic             accept;
    logic             test_en;
    logic [WIDTH-1:0] older;
    logic             peak;
    logic             empty;
    logic             full;
    logic             rd_en;
    logic             can_wr;
    logic             drop;
    logic [99:0]      wr_data;
    logic [15:0]      range_nxt;

    assign accept  = sample_vld && (armed || sweep_start);
    assign test_en = accept && !sweep_start && w1_vld;
    assign older   = w2_vld ? w2 : '0;
    assign peak    = test_en && (w1 > threshold)
                  && (w1 >= older) && (w1 > sample);

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW])
                 && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en  = !empty && word_rdy;
    assign can_wr = pend_vld && !full && (det_num < 12'(MAX_DET));
    assign drop   = pend_vld && !can_wr;

    assign wr_data = {pend_az, pend_rng, pend_amp, pend_sw, det_num,
                      ovf_pend, pend_edge, (pend_amp == '1),
                      1'b0, 4'hA};

    assign wr_word = !empty;
    assign word    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign range_nxt = (range_idx == 16'hFFFF) ? range_idx
                                               : range_idx + 16'd1;

    // Sweep bookkeeping and sample window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            az_q      <= '0;
            sweep_cnt <= '0;
            range_idx <= '0;
            w1        <= '0;
            w2        <= '0;
            w1_vld    <= 1'b0;
            w2_vld    <= 1'b0;
            r1        <= '0;
        end else if (sweep_start) begin
            armed     <= 1'b1;
            az_q      <= azimuth;
            sweep_cnt <= sweep_cnt + 16'd1;
            range_idx <= sample_vld ? 16'd1 : 16'd0;
            w1        <= sample;
            w1_vld    <= sample_vld;
            w2_vld    <= 1'b0;
            r1        <= '0;
        end else if (accept) begin
            range_idx <= range_nxt;
            w2        <= w1;
            w2_vld    <= w1_vld;
            w1        <= sample;
            w1_vld    <= 1'b1;
            r1        <= range_idx;
        end
    end

    // Detected peak is staged one cycle before the FIFO write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_az   <= '0;
            pend_rng  <= '0;
            pend_amp  <= '0;
            pend_sw   <= '0;
            pend_edge <= 1'b0;
        end else begin
            pend_vld <= peak;
            if (peak) begin
                pend_az   <= az_q;
                pend_rng  <= r1;
                pend_amp  <= w1;
                pend_sw   <= sweep_cnt;
                pend_edge <= !w2_vld;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_num  <= '0;
            ovf_pend <= 1'b0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (sweep_start)
                det_num <= '0;
            else if (can_wr)
                det_num <= det_num + 12'd1;
            if (can_wr)
                ovf_pend <= 1'b0;
            else if (drop)
                ovf_pend <= 1'b1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (can_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (can_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_mfic_det_packer.sv
// Scoreboard bench for mfic_det_packer: default instance plus a MAX_DET=2
// instance sharing sample, threshold and azimuth.
module tb_mfic_det_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        sweep_start, sweep_start2;
    logic [31:0] sample;
    logic        sample_vld, sample_vld2;
    logic [31:0] threshold;
    logic [15:0] azimuth;
    logic [99:0] word, word2;
    logic        wr_word, wr_word2;
    logic        word_rdy, word_rdy2;
    logic [15:0] drop_cnt, drop_cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int sw = 0;
    int sw2 = 0;
    logic [99:0] q[$];
    logic [99:0] q2[$];

    always #5 clk = ~clk;

    mfic_det_packer u_dut (
        .clk(clk), .reset(reset), .sweep_start(sweep_start),
        .sample(sample), .sample_vld(sample_vld),
        .threshold(threshold), .azimuth(azimuth),
        .word(word), .wr_word(wr_word), .word_rdy(word_rdy),
        .drop_cnt(drop_cnt)
    );

    mfic_det_packer #(.MAX_DET(2)) u_dut2 (
        .clk(clk), .reset(reset), .sweep_start(sweep_start2),
        .sample(sample), .sample_vld(sample_vld2),
        .threshold(threshold), .azimuth(azimuth),
        .word(word2), .wr_word(wr_word2), .word_rdy(word_rdy2),
        .drop_cnt(drop_cnt2)
    );

    function automatic logic [99:0] mk(
        input logic [15:0] az, input logic [15:0] rng,
        input logic [31:0] amp, input logic [15:0] swc,
        input logic [11:0] det, input logic ovf, input logic edg);
        return {az, rng, amp, swc, det, ovf, edg,
                (amp == 32'hFFFFFFFF), 1'b0, 4'hA};
    endfunction

    always @(negedge clk) begin
        if (wr_word && word_rdy) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word got=%h", word);
            end else begin
                if (word !== q[0]) begin
                    n_bad++;
                    $display("FAIL word got=%h exp=%h", word, q[0]);
                end
                void'(q.pop_front());
            end
        end
        if (wr_word2 && word_rdy2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word2 got=%h", word2);
            end else begin
                if (word2 !== q2[0]) begin
                    n_bad++;
                    $display("FAIL word2 got=%h exp=%h", word2, q2[0]);
                end
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        sample = v;
        sample_vld = 1'b1;
        tick();
        sample_vld = 1'b0;
    endtask

    task automatic send2(input logic [31:0] v);
        sample = v;
        sample_vld2 = 1'b1;
        tick();
        sample_vld2 = 1'b0;
    endtask

    task automatic sweep(input logic [15:0] az);
        azimuth = az;
        sweep_start = 1'b1;
        sw++;
        tick();
        sweep_start = 1'b0;
    endtask

    task automatic sweep_v(input logic [15:0] az, input logic [31:0] v);
        azimuth = az;
        sample = v;
        sweep_start = 1'b1;
        sample_vld = 1'b1;
        sw++;
        tick();
        sweep_start = 1'b0;
        sample_vld = 1'b0;
    endtask

    task automatic sweep2(input logic [15:0] az);
        azimuth = az;
        sweep_start2 = 1'b1;
        sw2++;
        tick();
        sweep_start2 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q.size() != 0 || q2.size() != 0); i++)
            tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sweep_start = 0; sweep_start2 = 0;
        sample = 0; sample_vld = 0; sample_vld2 = 0;
        threshold = 32'd10; azimuth = 0;
        word_rdy = 1'b1; word_rdy2 = 1'b1;
        #3;
        n_cmp++;
        if (wr_word !== 1'b0 || word !== '0 || drop_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_state got=%b/%h/%0d exp=0/0/0",
                     wr_word, word, drop_cnt);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        send(1); send(50); send(1);
        tick(); tick(); tick();
        n_cmp++;
        if (wr_word !== 1'b0) begin
            n_bad++;
            $display("FAIL unarmed got=%b exp=0", wr_word);
        end
    endtask

    task automatic test_basic();
        sweep(100);
        q.push_back(mk(100, 1, 20, 16'(sw), 0, 0, 0));
        send(5); send(20); send(9);
        n_cmp++;
        if (wr_word !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early got=%b exp=0", wr_word);
        end
        tick();
        n_cmp++;
        if (wr_word !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_due got=%b exp=1", wr_word);
        end
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL basic_drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_plateau();
        sweep(200);
        q.push_back(mk(200, 2, 20, 16'(sw), 0, 0, 0));
        q.push_back(mk(200, 5, 32'hFFFFFFFF, 16'(sw), 1, 0, 0));
        send(5); send(20); send(20); send(9);
        send(1); send(32'hFFFFFFFF); send(1);
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL plateau_drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_edge();
        sweep(300);
        q.push_back(mk(300, 0, 50, 16'(sw), 0, 0, 1));
        send(50); send(7); send(1); send(50);
        q.push_back(mk(301, 0, 40, 16'(sw + 1), 0, 0, 1));
        sweep_v(301, 40);
        send(5); send(3); send(2);
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL edge_drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_stall();
        word_rdy = 1'b0;
        sweep(400);
        send(1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4)
                q.push_back(mk(400, 16'(2 * i + 1), 32'(100 + i),
                               16'(sw), 12'(i), 0, 0));
            send(32'(100 + i));
            send(1);
        end
        tick(); tick();
        n_cmp++;
        if (drop_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL stall_drops got=%0d exp=2", drop_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wr_word !== 1'b1 || word !== q[0]) begin
                n_bad++;
                $display("FAIL stall_hold got=%h exp=%h", word, q[0]);
            end
            tick();
        end
        word_rdy = 1'b1;
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_drain left=%0d exp=0", q.size());
        end
        q.push_back(mk(400, 13, 60, 16'(sw), 4, 1, 0));
        q.push_back(mk(400, 15, 70, 16'(sw), 5, 0, 0));
        send(60); send(1); send(70); send(1);
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_max_det();
        sweep2(500);
        q2.push_back(mk(500, 1, 30, 16'(sw2), 0, 0, 0));
        q2.push_back(mk(500, 3, 31, 16'(sw2), 1, 0, 0));
        send2(1);
        send2(30); send2(1); send2(31); send2(1); send2(32); send2(1);
        drain();
        n_cmp++;
        if (drop_cnt2 !== 16'd1 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL max_det got=%0d/%0d exp=1/0",
                     drop_cnt2, q2.size());
        end
        sweep2(501);
        q2.push_back(mk(501, 1, 33, 16'(sw2), 0, 1, 0));
        send2(1); send2(33); send2(1);
        drain();
        n_cmp++;
        if (q2.size() != 0) begin
            n_bad++;
            $display("FAIL max_det_restart left=%0d exp=0", q2.size());
        end
    endtask

    task automatic test_reset_mid();
        word_rdy = 1'b0;
        sweep(600);
        send(1);
        for (int i = 0; i < 3; i++) begin
            send(32'(200 + i));
            send(1);
        end
        tick(); tick();
        n_cmp++;
        if (wr_word !== 1'b1) begin
            n_bad++;
            $display("FAIL queued got=%b exp=1", wr_word);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (wr_word !== 1'b0 || word !== '0 || drop_cnt !== '0) begin
            n_bad++;
            $display("FAIL async_reset got=%b/%h/%0d exp=0/0/0",
                     wr_word, word, drop_cnt);
        end
        sw = 0;
        tick();
        reset = 1'b0;
        word_rdy = 1'b1;
        send(1); send(80); send(1);
        tick(); tick(); tick();
        n_cmp++;
        if (wr_word !== 1'b0) begin
            n_bad++;
            $display("FAIL rearm got=%b exp=0", wr_word);
        end
        sweep(700);
        q.push_back(mk(700, 1, 90, 16'(sw), 0, 0, 0));
        send(1); send(90); send(1);
        drain();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL after_reset left=%0d exp=0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_plateau();
        test_edge();
        test_stall();
        test_max_det();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
